// File: rtl/mcu_debug_responder.sv
// mcu_debug_responder: debug command responder that halts the Otter pipe and performs reg/mem accesses.
// Define DBG_MEM_TIMEOUT_EN to abandon memory accesses that see no dm_ack within MEM_TIMEOUT cycles.
module mcu_debug_responder #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int RESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic        mcu_busy,
  output logic [31:0] d_rd,
  output logic        error,
  output logic        halted,
  output logic        stall_fetch,
  input  logic        pipe_empty,
  output logic        pipe_reset,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  input  logic [31:0] rf_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_rd,
  output logic        dm_we,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [2:0] {RUN, DRAIN, HALTED, REG_ACC, MEM_ACC, RST} state_t;
  if (RESET_CYCLES < 1 || MEM_TIMEOUT < 1) begin : g_bad_params
    $error("mcu_debug_responder: RESET_CYCLES and MEM_TIMEOUT must be >= 1");
  end
  state_t r_state, w_state;
  logic r_busy, w_busy, r_err, w_err, r_perr, w_perr;
  logic r_res, w_res, r_rd, w_rd, r_wr, w_wr;
  logic [31:0] r_drd, w_drd, r_addr, w_addr, r_din, w_din;
  logic [RW-1:0] r_rcnt, w_rcnt;
  logic [6:0] w_req;
  logic w_legal, w_accept;
`ifdef DBG_MEM_TIMEOUT_EN
  localparam int TW = MEM_TIMEOUT > 255 ? $clog2(MEM_TIMEOUT + 1) : 8;
  logic [TW-1:0] r_tcnt, w_tcnt;
`endif
  assign w_req = {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr};
  assign w_legal = $onehot(w_req);
  // a reset command is the only thing allowed to cut a drain short
  assign w_accept = valid && (!r_busy || (r_state == DRAIN && w_legal && reset));
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_perr  <= 1'b0;
      r_res   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_drd   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_rcnt  <= '0;
`ifdef DBG_MEM_TIMEOUT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_busy  <= w_busy;
      r_err   <= w_err;
      r_perr  <= w_perr;
      r_res   <= w_res;
      r_rd    <= w_rd;
      r_wr    <= w_wr;
      r_drd   <= w_drd;
      r_addr  <= w_addr;
      r_din   <= w_din;
      r_rcnt  <= w_rcnt;
`ifdef DBG_MEM_TIMEOUT_EN
      r_tcnt  <= w_tcnt;
`endif
    end
  end
  always_comb begin
    w_state = r_state;
    w_busy  = r_busy;
    w_err   = r_err;
    w_perr  = r_perr;
    w_res   = r_res;
    w_rd    = r_rd;
    w_wr    = r_wr;
    w_drd   = r_drd;
    w_addr  = r_addr;
    w_din   = r_din;
    w_rcnt  = r_rcnt;
`ifdef DBG_MEM_TIMEOUT_EN
    w_tcnt  = r_tcnt;
`endif
    if (w_accept) begin
      w_busy = 1'b1;
      w_err  = 1'b0;
      w_perr = !w_legal;
      w_res  = resume;
      w_rd   = reg_rd | mem_rd;
      w_wr   = reg_wr | mem_wr;
      w_addr = addr;
      w_din  = d_in;
      w_rcnt = '0;
`ifdef DBG_MEM_TIMEOUT_EN
      w_tcnt = '0;
`endif
      if (!w_legal) w_state = r_state;
      else if (reset) w_state = RST;
      else if (r_state == RUN) begin
        w_state = pause ? DRAIN : RUN;
        w_perr  = !(pause || resume);
      end else if (reg_rd || reg_wr) begin
        w_perr  = |addr[31:5];
        w_state = w_perr ? HALTED : REG_ACC;
      end else if (mem_rd || mem_wr) begin
        w_perr  = |addr[1:0];
        w_state = w_perr ? HALTED : MEM_ACC;
      end
    end else if (r_busy) begin
      case (r_state)
        DRAIN: begin
          w_state = pipe_empty ? HALTED : DRAIN;
          w_busy  = !pipe_empty;
        end
        REG_ACC: begin
          w_state = HALTED;
          w_busy  = 1'b0;
          w_drd   = r_rd ? rf_rdata : r_drd;
        end
        MEM_ACC: begin
          if (dm_ack) begin
            w_state = HALTED;
            w_busy  = 1'b0;
            w_drd   = r_rd ? dm_rdata : r_drd;
          end
`ifdef DBG_MEM_TIMEOUT_EN
          else if (r_tcnt == TW'(MEM_TIMEOUT - 1)) begin
            w_state = HALTED;
            w_busy  = 1'b0;
            w_err   = 1'b1;
            w_drd   = '0;
          end else w_tcnt = r_tcnt + 1'b1;
`endif
        end
        RST: begin
          if (r_rcnt == RW'(RESET_CYCLES - 1)) begin
            w_state = RUN;
            w_busy  = 1'b0;
          end else w_rcnt = r_rcnt + 1'b1;
        end
        default: begin
          w_busy  = 1'b0;
          w_err   = r_perr;
          w_state = (r_state == HALTED && r_res && !r_perr) ? RUN : r_state;
        end
      endcase
    end
  end
  assign mcu_busy    = r_busy;
  assign d_rd        = r_drd;
  assign error       = r_err;
  assign halted      = r_state inside {HALTED, REG_ACC, MEM_ACC};
  assign stall_fetch = r_state inside {DRAIN, HALTED, REG_ACC, MEM_ACC};
  assign pipe_reset  = r_state == RST;
  assign rf_addr     = r_addr[4:0];
  assign rf_wdata    = r_din;
  assign rf_we       = r_state == REG_ACC && r_wr && |r_addr[4:0];
  assign dm_addr     = r_addr;
  assign dm_wdata    = r_din;
  assign dm_rd       = r_state == MEM_ACC && r_rd;
  assign dm_we       = r_state == MEM_ACC && r_wr;
endmodule

// File: tb/tb_mcu_debug_responder.sv
// tb_mcu_debug_responder: scoreboard bench for mcu_debug_responder.
// Expected error/d_rd/busy-length per command are queued at issue and popped when busy falls.
module tb_mcu_debug_responder;
  localparam logic [6:0] C_PAUSE  = 7'b1000000;
  localparam logic [6:0] C_RESUME = 7'b0100000;
  localparam logic [6:0] C_RESET  = 7'b0010000;
  localparam logic [6:0] C_RRD    = 7'b0001000;
  localparam logic [6:0] C_RWR    = 7'b0000100;
  localparam logic [6:0] C_MRD    = 7'b0000010;
  localparam logic [6:0] C_MWR    = 7'b0000001;
  typedef struct {
    string       nm;
    logic        err;
    logic [31:0] drd;
    int          cyc;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0, valid = 1'b0;
  logic pause = 1'b0, resume = 1'b0, reset = 1'b0, reg_rd = 1'b0, reg_wr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] addr = '0, d_in = '0, dm_rdata = '0;
  logic pipe_empty = 1'b0, dm_ack = 1'b0;
  logic mcu_busy, error, halted, stall_fetch, pipe_reset, rf_we, dm_rd, dm_we;
  logic [31:0] d_rd, rf_wdata, rf_rdata, dm_addr, dm_wdata;
  logic [4:0] rf_addr;
  logic [31:0] regs [32];
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int ack_at = -1, empty_at = -1;
  int n_we, n_dmrd, n_dmwe, n_pr;
  logic [31:0] cap_addr, cap_wdata, exp_drd;
  mcu_debug_responder dut (
    .clk(clk), .reset_n(reset_n), .valid(valid),
    .pause(pause), .resume(resume), .reset(reset),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr(addr), .d_in(d_in),
    .mcu_busy(mcu_busy), .d_rd(d_rd), .error(error), .halted(halted),
    .stall_fetch(stall_fetch), .pipe_empty(pipe_empty), .pipe_reset(pipe_reset),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rd(dm_rd), .dm_we(dm_we),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) if (rf_we) regs[rf_addr] <= rf_wdata;
  assign rf_rdata = regs[rf_addr];
  // drives one command and follows it until busy falls or lim busy cycles elapse
  task automatic send(input logic [6:0] c, input logic [31:0] a, input logic [31:0] d, input int lim, output int cyc);
    {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = c;
    valid = 1'b1;
    addr = a;
    d_in = d;
    n_we = 0; n_dmrd = 0; n_dmwe = 0; n_pr = 0; cyc = 0;
    @(posedge clk); #1;
    valid = 1'b0;
    {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = '0;
    while (mcu_busy && cyc < lim) begin
      cyc++;
      pipe_empty = empty_at >= 0 && cyc >= empty_at;
      dm_ack = cyc == ack_at;
      n_we += int'(rf_we); n_dmrd += int'(dm_rd); n_dmwe += int'(dm_we); n_pr += int'(pipe_reset);
      if (dm_rd || dm_we) begin cap_addr = dm_addr; cap_wdata = dm_wdata; end
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
    pipe_empty = 1'b0;
  endtask
  task automatic test_reset;
    logic [31:0] got;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {mcu_busy, error, halted, stall_fetch, pipe_reset, rf_we, dm_rd, dm_we, d_rd[23:0]};
    n_cmp++;
    if (got !== 32'h0 || d_rd !== 32'h0) begin n_bad++; $display("FAIL reset_state: got %h d_rd=%h want 0", got, d_rd); end
    reset_n = 1'b1;
    exp_drd = '0;
    @(posedge clk); #1;
  endtask
  task automatic test_run_cmds;
    int cyc; exp_t e;
    sb.push_back('{"mem_rd_in_run", 1'b1, exp_drd, 1});
    send(C_MRD, 32'h1000, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
    n_cmp++;
    if (n_dmrd !== 0) begin n_bad++; $display("FAIL mem_rd_in_run_dm_rd: %0d cycles want 0", n_dmrd); end
    sb.push_back('{"reg_wr_in_run", 1'b1, exp_drd, 1});
    send(C_RWR, 32'h3, 32'h55, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
    n_cmp++;
    if (n_we !== 0 || regs[3] !== 32'h0) begin n_bad++; $display("FAIL reg_wr_in_run_rf_we: %0d cycles x3=%h want 0", n_we, regs[3]); end
    sb.push_back('{"resume_in_run", 1'b0, exp_drd, 1});
    send(C_RESUME, 32'h0, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc, halted, stall_fetch} !== {e.err, e.drd, e.cyc, 2'b00}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d halted=%0b want %0b %h %0d 0", e.nm, error, d_rd, cyc, halted, e.err, e.drd, e.cyc); end
  endtask
  task automatic test_pause;
    int cyc; exp_t e;
    empty_at = 3;
    sb.push_back('{"pause_drain", 1'b0, exp_drd, 3});
    send(C_PAUSE, 32'h0, 32'h0, 1000, cyc);
    empty_at = -1;
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc, halted, stall_fetch} !== {e.err, e.drd, e.cyc, 2'b11}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d halted=%0b stall=%0b want %0b %h %0d 1 1", e.nm, error, d_rd, cyc, halted, stall_fetch, e.err, e.drd, e.cyc); end
  endtask
  task automatic test_reg;
    int cyc; exp_t e;
    sb.push_back('{"reg_wr_x5", 1'b0, exp_drd, 1});
    send(C_RWR, 32'd5, 32'hDEADBEEF, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
    n_cmp++;
    if (n_we !== 1 || regs[5] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL reg_wr_x5_we: rf_we %0d cycles x5=%h want 1 deadbeef", n_we, regs[5]); end
    exp_drd = 32'hDEADBEEF;
    sb.push_back('{"reg_rd_x5", 1'b0, exp_drd, 1});
    send(C_RRD, 32'd5, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
    sb.push_back('{"reg_wr_x0", 1'b0, exp_drd, 1});
    send(C_RWR, 32'd0, 32'h12345678, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
    n_cmp++;
    if (n_we !== 0) begin n_bad++; $display("FAIL reg_wr_x0_we: rf_we %0d cycles want 0", n_we); end
    sb.push_back('{"reg_rd_bad_addr", 1'b1, exp_drd, 1});
    send(C_RRD, 32'h20, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
  endtask
  task automatic test_mem;
    int cyc; exp_t e;
    sb.push_back('{"mem_rd_misaligned", 1'b1, exp_drd, 1});
    send(C_MRD, 32'h1002, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
    n_cmp++;
    if (n_dmrd !== 0) begin n_bad++; $display("FAIL mem_rd_misaligned_req: dm_rd %0d cycles want 0", n_dmrd); end
    dm_rdata = 32'h1000A5A5;
    ack_at = 3;
    exp_drd = 32'h1000A5A5;
    sb.push_back('{"mem_rd_1000", 1'b0, exp_drd, 3});
    send(C_MRD, 32'h1000, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
    n_cmp++;
    if (n_dmrd !== 3 || cap_addr !== 32'h1000) begin n_bad++; $display("FAIL mem_rd_1000_req: dm_rd %0d cycles addr=%h want 3 00001000", n_dmrd, cap_addr); end
    ack_at = 2;
    dm_rdata = 32'hFFFFFFFF;
    sb.push_back('{"mem_wr_2000", 1'b0, exp_drd, 2});
    send(C_MWR, 32'h2000, 32'h12345678, 1000, cyc);
    ack_at = -1;
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc} !== {e.err, e.drd, e.cyc}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d want %0b %h %0d", e.nm, error, d_rd, cyc, e.err, e.drd, e.cyc); end
    n_cmp++;
    if ({n_dmwe, n_dmrd, cap_addr, cap_wdata} !== {32'd2, 32'd0, 32'h2000, 32'h12345678}) begin n_bad++; $display("FAIL mem_wr_2000_req: we=%0d rd=%0d addr=%h data=%h want 2 0 00002000 12345678", n_dmwe, n_dmrd, cap_addr, cap_wdata); end
    dm_ack = 1'b1;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({mcu_busy, halted, dm_rd, dm_we, d_rd} !== {4'b0100, exp_drd}) begin n_bad++; $display("FAIL stray_ack: busy=%0b halted=%0b dm_rd=%0b dm_we=%0b d_rd=%h want 0 1 0 0 %h", mcu_busy, halted, dm_rd, dm_we, d_rd, exp_drd); end
  endtask
  task automatic test_illegal;
    int cyc; exp_t e;
    sb.push_back('{"pause_and_resume", 1'b1, exp_drd, 1});
    send(C_PAUSE | C_RESUME, 32'h0, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc, halted, stall_fetch} !== {e.err, e.drd, e.cyc, 2'b11}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d halted=%0b want %0b %h %0d 1", e.nm, error, d_rd, cyc, halted, e.err, e.drd, e.cyc); end
    sb.push_back('{"no_cmd_bits", 1'b1, exp_drd, 1});
    send(7'b0, 32'h0, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc, halted} !== {e.err, e.drd, e.cyc, 1'b1}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d halted=%0b want %0b %h %0d 1", e.nm, error, d_rd, cyc, halted, e.err, e.drd, e.cyc); end
  endtask
  task automatic test_back_to_back;
    int cyc; exp_t e;
    sb.push_back('{"step_resume", 1'b0, exp_drd, 1});
    send(C_RESUME, 32'h0, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc, halted, stall_fetch} !== {e.err, e.drd, e.cyc, 2'b00}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d halted=%0b stall=%0b want %0b %h %0d 0 0", e.nm, error, d_rd, cyc, halted, stall_fetch, e.err, e.drd, e.cyc); end
    empty_at = 2;
    sb.push_back('{"step_pause", 1'b0, exp_drd, 2});
    send(C_PAUSE, 32'h0, 32'h0, 1000, cyc);
    empty_at = -1;
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc, halted, stall_fetch} !== {e.err, e.drd, e.cyc, 2'b11}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d halted=%0b stall=%0b want %0b %h %0d 1 1", e.nm, error, d_rd, cyc, halted, stall_fetch, e.err, e.drd, e.cyc); end
  endtask
`ifdef DBG_MEM_TIMEOUT_EN
  task automatic test_timeout;
    int cyc; exp_t e;
    exp_drd = '0;
    sb.push_back('{"mem_wr_timeout", 1'b1, exp_drd, 255});
    send(C_MWR, 32'h4000, 32'hCAFEF00D, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc, halted, dm_we} !== {e.err, e.drd, e.cyc, 2'b10}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d halted=%0b dm_we=%0b want %0b %h %0d 1 0", e.nm, error, d_rd, cyc, halted, dm_we, e.err, e.drd, e.cyc); end
  endtask
`endif
  task automatic test_reset_cmd_mid_drain;
    int cyc; exp_t e;
    send(C_RESUME, 32'h0, 32'h0, 1000, cyc);
    send(C_PAUSE, 32'h0, 32'h0, 2, cyc);
    n_cmp++;
    if ({mcu_busy, stall_fetch, halted} !== 3'b110) begin n_bad++; $display("FAIL drain_in_progress: busy=%0b stall=%0b halted=%0b want 1 1 0", mcu_busy, stall_fetch, halted); end
    sb.push_back('{"reset_mid_drain", 1'b0, exp_drd, 4});
    send(C_RESET, 32'h0, 32'h0, 1000, cyc);
    e = sb.pop_front(); n_cmp++;
    if ({error, d_rd, cyc, halted, stall_fetch, pipe_reset} !== {e.err, e.drd, e.cyc, 3'b000}) begin n_bad++; $display("FAIL %s: err=%0b d_rd=%h busy=%0d halted=%0b stall=%0b want %0b %h %0d 0 0", e.nm, error, d_rd, cyc, halted, stall_fetch, e.err, e.drd, e.cyc); end
    n_cmp++;
    if (n_pr !== 4) begin n_bad++; $display("FAIL reset_pulse_len: pipe_reset %0d cycles want 4", n_pr); end
  endtask
  task automatic test_reset_n_mid_access;
    int cyc;
    logic [31:0] got;
    empty_at = 1;
    send(C_PAUSE, 32'h0, 32'h0, 1000, cyc);
    empty_at = -1;
    send(C_MRD, 32'h3000, 32'h77, 2, cyc);
    n_cmp++;
    if ({mcu_busy, dm_rd} !== 2'b11) begin n_bad++; $display("FAIL mem_in_flight: busy=%0b dm_rd=%0b want 1 1", mcu_busy, dm_rd); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    got = {mcu_busy, error, halted, stall_fetch, pipe_reset, rf_we, dm_rd, dm_we, rf_addr, 19'h0};
    n_cmp++;
    if (got !== 32'h0 || {d_rd, dm_addr, dm_wdata, rf_wdata} !== 128'h0) begin n_bad++; $display("FAIL reset_n_mid_access: ctl=%h d_rd=%h dm_addr=%h dm_wdata=%h want 0", got, d_rd, dm_addr, dm_wdata); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_run_cmds();
    test_pause();
    test_reg();
    test_mem();
    test_illegal();
    test_back_to_back();
`ifdef DBG_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_cmd_mid_drain();
    test_reset_n_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
